// File: rtl/package_param.sv
// rtl/package_param.sv - op classes and RV32I opcodes shared by the writer and the control unit
package package_param;

  typedef enum logic [3:0] {
    OP_R  = 4'd0,
    OP_I  = 4'd1,
    OP_IL = 4'd2,
    OP_S  = 4'd3,
    OP_B  = 4'd4,
    OP_IJ = 4'd5,
    OP_II = 4'd6,
    OP_U1 = 4'd7,
    OP_U2 = 4'd8
  } op_class_e;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] ILTYPE = 7'b0000011;
  localparam logic [6:0] STYPE  = 7'b0100011;
  localparam logic [6:0] BTYPE  = 7'b1100011;
  localparam logic [6:0] IJTYPE = 7'b1101111;
  localparam logic [6:0] IITYPE = 7'b1100111;
  localparam logic [6:0] U1TYPE = 7'b0110111;
  localparam logic [6:0] U2TYPE = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - combinational RV32I field-to-word encoder with illegal-bundle flag
module inst_encoder
  import package_param::*;
(
  input  logic [3:0]  op_class,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_class)
      OP_R:  word = {funct7, rs2, rs1, funct3, rd, RTYPE};
      OP_I: begin
        // slli/srli/srai carry funct7 in the upper immediate bits
        if (funct3 == 3'b001 || funct3 == 3'b101)
          word = {funct7, imm[4:0], rs1, funct3, rd, ITYPE};
        else
          word = {imm[11:0], rs1, funct3, rd, ITYPE};
      end
      OP_IL: word = {imm[11:0], rs1, funct3, rd, ILTYPE};
      OP_S:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], STYPE};
      OP_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], BTYPE};
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011) || imm[0];
      end
      OP_IJ: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, IJTYPE};
        illegal = imm[0];
      end
      OP_II: word = {imm[11:0], rs1, 3'b000, rd, IITYPE};
      OP_U1: word = {imm[31:12], rd, U1TYPE};
      OP_U2: word = {imm[31:12], rd, U2TYPE};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_writer.sv
// rtl/imem_program_writer.sv - session FSM that encodes accepted bundles and writes them to consecutive imem words
module imem_program_writer
  import package_param::*;
#(
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_op_class,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  input  logic              i_last,
  output logic              o_imem_wren,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  wr_state_e         state;
  logic [ADDR_W-1:0] ptr;
  logic              full;
  logic [31:0]       enc_word;
  logic              enc_illegal;

  inst_encoder u_enc (
    .op_class (i_op_class),
    .funct3   (i_funct3),
    .funct7   (i_funct7),
    .rd       (i_rd),
    .rs1      (i_rs1),
    .rs2      (i_rs2),
    .imm      (i_imm),
    .word     (enc_word),
    .illegal  (enc_illegal)
  );

  assign o_ready = (state == S_RUN);
  assign o_busy  = (state == S_RUN) || (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      ptr          <= ADDR_W'(BASE_ADDR);
      full         <= 1'b0;
      o_count      <= '0;
      o_imem_wren  <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_imem_wren <= 1'b0;
      o_done      <= 1'b0;
      if (i_start) begin
        state   <= S_RUN;
        ptr     <= ADDR_W'(BASE_ADDR);
        full    <= 1'b0;
        o_count <= '0;
        o_err   <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            if (i_valid) begin
              // full means the top address is already written; refuse rather than wrap
              if (enc_illegal || full) begin
                o_err <= 1'b1;
                state <= S_ERR;
              end else begin
                o_imem_wren  <= 1'b1;
                o_imem_addr  <= ptr;
                o_imem_wdata <= enc_word;
                ptr          <= ptr + 1'b1;
                o_count      <= o_count + 1'b1;
                if (ptr == '1) full <= 1'b1;
                if (i_last) begin
                  o_done <= 1'b1;
                  state  <= S_DONE;
                end
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_program_writer.sv
// tb/tb_imem_program_writer.sv - directed self-checking bench for imem_program_writer
module tb_imem_program_writer;
  import package_param::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, valid = 1'b0;
  logic        start2 = 1'b0, valid2 = 1'b0;
  logic [3:0]  op_class = '0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        last = 1'b0;

  logic        ready, wren, busy, done, err;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic [11:0] count;

  logic        ready2, wren2, busy2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  count2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imem_program_writer #(.ADDR_W(11), .BASE_ADDR(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .o_ready(ready),
    .i_op_class(op_class), .i_funct3(f3), .i_funct7(f7), .i_rd(rd), .i_rs1(rs1),
    .i_rs2(rs2), .i_imm(imm), .i_last(last), .o_imem_wren(wren), .o_imem_addr(addr),
    .o_imem_wdata(wdata), .o_count(count), .o_busy(busy), .o_done(done), .o_err(err)
  );

  imem_program_writer #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_valid(valid2), .o_ready(ready2),
    .i_op_class(op_class), .i_funct3(f3), .i_funct7(f7), .i_rd(rd), .i_rs1(rs1),
    .i_rs2(rs2), .i_imm(imm), .i_last(1'b0), .o_imem_wren(wren2), .o_imem_addr(addr2),
    .o_imem_wdata(wdata2), .o_count(count2), .o_busy(busy2), .o_done(done2), .o_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fields(input logic [3:0] oc, input logic [2:0] ff3, input logic [6:0] ff7,
                        input logic [4:0] frd, input logic [4:0] frs1, input logic [4:0] frs2,
                        input logic [31:0] fimm, input logic flast);
    op_class = oc; f3 = ff3; f7 = ff7; rd = frd; rs1 = frs1; rs2 = frs2; imm = fimm; last = flast;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic [10:0] a, input logic [31:0] d);
    chk({tag, "_wren"}, 32'(wren), 32'd1);
    chk({tag, "_addr"}, 32'(addr), 32'(a));
    chk({tag, "_data"}, wdata, d);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(ready), 32'd0);

    // session 1: add / addi / srai(last)
    do_start();
    chk("s1_ready", 32'(ready), 32'd1);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_count0", 32'(count), 32'd0);
    fields(OP_R, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    valid = 1'b1;
    tick();
    chk_write("add", 11'd0, 32'h002081B3);
    fields(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    tick();
    chk_write("addi", 11'd1, 32'h00500093);
    fields(OP_I, 3'b101, 7'b0100000, 5'd4, 5'd4, 5'd0, 32'd3, 1'b1);
    tick();
    valid = 1'b0;
    last = 1'b0;
    chk_write("srai", 11'd2, 32'h40325213);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_count", 32'(count), 32'd3);
    tick();
    chk("s1_idle_busy", 32'(busy), 32'd0);
    chk("s1_idle_done", 32'(done), 32'd0);
    chk("s1_idle_wren", 32'(wren), 32'd0);

    // session 2: beq / jal / sw / lui(last)
    do_start();
    fields(OP_B, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    valid = 1'b1;
    tick();
    chk_write("beq", 11'd0, 32'h00208463);
    fields(OP_IJ, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0);
    tick();
    chk_write("jal", 11'd1, 32'h010000EF);
    fields(OP_S, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0);
    tick();
    chk_write("sw", 11'd2, 32'h0020A623);
    fields(OP_U1, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
    tick();
    valid = 1'b0;
    last = 1'b0;
    chk_write("lui", 11'd3, 32'h123452B7);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_count", 32'(count), 32'd4);
    tick();

    // errors: B with funct3=010, jal odd offset, unknown op class
    do_start();
    fields(OP_B, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("berr_wren", 32'(wren), 32'd0);
    chk("berr_err", 32'(err), 32'd1);
    chk("berr_ready", 32'(ready), 32'd0);
    tick();
    chk("berr_sticky", 32'(err), 32'd1);
    do_start();
    chk("berr_clear", 32'(err), 32'd0);
    chk("berr_ready2", 32'(ready), 32'd1);
    fields(OP_IJ, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("jerr_wren", 32'(wren), 32'd0);
    chk("jerr_err", 32'(err), 32'd1);
    do_start();
    fields(4'hF, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("uerr_wren", 32'(wren), 32'd0);
    chk("uerr_err", 32'(err), 32'd1);

    // valid toggling every other cycle
    do_start();
    fields(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk_write("gap0", 11'd0, 32'h00500093);
    tick();
    chk("gap_idle", 32'(wren), 32'd0);
    fields(OP_R, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk_write("gap1", 11'd1, 32'h002081B3);
    tick();
    chk("gap_idle2", 32'(wren), 32'd0);
    chk("gap_count", 32'(count), 32'd2);

    // restart mid-stream: registered write at 2 issues, then next write at base
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk_write("pre_restart", 11'd2, 32'h002081B3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_count0", 32'(count), 32'd0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk_write("restart", 11'd0, 32'h002081B3);
    chk("restart_count1", 32'(count), 32'd1);

    // async reset right after an accept drops the write
    valid = 1'b1;
    tick();
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("areset_wren", 32'(wren), 32'd0);
    chk("areset_addr", 32'(addr), 32'd0);
    chk("areset_data", wdata, 32'd0);
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("areset_nostrobe", 32'(wren), 32'd0);
    chk("areset_idle", 32'(ready), 32'd0);

    // ADDR_W=2: four writes at 0..3, fifth errors without wrapping
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    fields(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("small_wren%0d", i), 32'(wren2), 32'd1);
      chk($sformatf("small_addr%0d", i), 32'(addr2), 32'(i));
    end
    chk("small_count", 32'(count2), 32'd4);
    tick();
    valid2 = 1'b0;
    chk("small_ovf_wren", 32'(wren2), 32'd0);
    chk("small_ovf_err", 32'(err2), 32'd1);
    chk("small_ovf_ready", 32'(ready2), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
